pwm_capture: RTL and testbench

Avalon-MM slave peripheral that measures an incoming PWM signal, such as an RC receiver channel or an external motor-driver feedback line. It reports high time and period in clock cycles and is the receiving counterpart of the pwmbrushed/pwmservo generators. It sits in the soc_system fabric beside the PWM generators. The HPS reads it over the lightweight bridge, and `pwm_in` is exported as a conduit.

---
 rtl/pwm_capture_pkg.sv | 21 ++
 rtl/pwm_sync_edge.sv | 38 +++
 rtl/pwm_capture.sv | 195 +++++++++++++++++++
 tb/tb_pwm_capture.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_capture_pkg.sv
// Shared types and constants for the PWM capture peripheral: FSM states,
// register addresses and STATUS/CTRL bit positions.
package pwm_capture_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HIGH = 2'd1,
      ST_LOW  = 2'd2
   } state_e;

   localparam logic [1:0] ADDR_HIGH   = 2'd0;
   localparam logic [1:0] ADDR_PERIOD = 2'd1;
   localparam logic [1:0] ADDR_STATUS = 2'd2;
   localparam logic [1:0] ADDR_CTRL   = 2'd3;

   localparam int STATUS_VALID_BIT   = 0;
   localparam int STATUS_TIMEOUT_BIT = 1;
   localparam int STATUS_PWM_BIT     = 2;
   localparam int CTRL_ENABLE_BIT    = 0;

endpackage

// File: rtl/pwm_sync_edge.sv
// Two-flop synchronizer plus a delay stage for single-cycle rise/fall pulses
// on an asynchronous input.
module pwm_sync_edge (
   input  logic clk,
   input  logic reset_n,
   input  logic async_in,
   output logic sync_out,
   output logic rise,
   output logic fall
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;
   logic dly_q, dly_d;

   always_comb begin
      meta_d = async_in;
      sync_d = meta_q;
      dly_d  = sync_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         dly_q  <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         dly_q  <= dly_d;
      end
   end

   assign sync_out = sync_q;
   assign rise     = sync_q & ~dly_q;
   assign fall     = ~sync_q & dly_q;

endmodule

// File: rtl/pwm_capture.sv
// Avalon-MM PWM capture: measures high time and period of pwm_in in clock
// cycles, with timeout detection and a coherent HIGH/PERIOD read pair.
module pwm_capture
   import pwm_capture_pkg::*;
#(
   parameter int CNT_W   = 24,
   parameter int TIMEOUT = 5_000_000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  address,
   input  logic        read,
   output logic [31:0] readdata,
   input  logic        write,
   input  logic [31:0] writedata,
   input  logic        pwm_in
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0]    TO_LAST = TW'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic pwm_s, rise, fall;

   pwm_sync_edge u_sync (
      .clk      (clk),
      .reset_n  (reset_n),
      .async_in (pwm_in),
      .sync_out (pwm_s),
      .rise     (rise),
      .fall     (fall)
   );

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  hcnt_q, hcnt_d;
   logic [CNT_W-1:0]  pcnt_q, pcnt_d;
   logic [CNT_W-1:0]  h_hold_q, h_hold_d;
   logic [CNT_W-1:0]  high_q, high_d;
   logic [CNT_W-1:0]  period_q, period_d;
   logic [CNT_W-1:0]  shadow_q, shadow_d;
   logic [TW-1:0]     tcnt_q, tcnt_d;
   logic              valid_q, valid_d;
   logic              timeout_q, timeout_d;
   logic              enable_q, enable_d;
   logic [31:0]       readdata_q, readdata_d;

   logic              valid_set, timeout_set, tcnt_expire;
   logic [CNT_W-1:0]  hcnt_inc, pcnt_inc;
   logic              unused_wdata;

   assign unused_wdata = ^writedata[31:2];

   // Counters saturate at all-ones rather than wrapping.
   assign hcnt_inc    = (hcnt_q == CNT_MAX) ? hcnt_q : hcnt_q + CNT_ONE;
   assign pcnt_inc    = (pcnt_q == CNT_MAX) ? pcnt_q : pcnt_q + CNT_ONE;
   assign tcnt_expire = !(rise || fall) && (tcnt_q == TO_LAST);

   always_comb begin
      state_d     = state_q;
      hcnt_d      = hcnt_q;
      pcnt_d      = pcnt_q;
      h_hold_d    = h_hold_q;
      high_d      = high_q;
      period_d    = period_q;
      tcnt_d      = tcnt_q;
      valid_set   = 1'b0;
      timeout_set = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (enable_q && rise) begin
               hcnt_d  = CNT_ONE;
               pcnt_d  = CNT_ONE;
               tcnt_d  = '0;
               state_d = ST_HIGH;
            end
         end
         ST_HIGH: begin
            if (!enable_q) begin
               state_d = ST_IDLE;
            end else if (tcnt_expire) begin
               timeout_set = 1'b1;
               high_d      = '0;
               period_d    = '0;
               tcnt_d      = '0;
               state_d     = ST_IDLE;
            end else if (fall) begin
               h_hold_d = hcnt_q;
               pcnt_d   = pcnt_inc;
               tcnt_d   = '0;
               state_d  = ST_LOW;
            end else begin
               hcnt_d = hcnt_inc;
               pcnt_d = pcnt_inc;
               tcnt_d = tcnt_q + TW'(1);
            end
         end
         ST_LOW: begin
            if (!enable_q) begin
               state_d = ST_IDLE;
            end else if (tcnt_expire) begin
               timeout_set = 1'b1;
               high_d      = '0;
               period_d    = '0;
               tcnt_d      = '0;
               state_d     = ST_IDLE;
            end else if (rise) begin
               high_d    = h_hold_q;
               period_d  = pcnt_q;
               valid_set = 1'b1;
               hcnt_d    = CNT_ONE;
               pcnt_d    = CNT_ONE;
               tcnt_d    = '0;
               state_d   = ST_HIGH;
            end else begin
               pcnt_d = pcnt_inc;
               tcnt_d = tcnt_q + TW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Hardware sets are applied after W1C so a same-cycle set wins.
   always_comb begin
      readdata_d = '0;
      shadow_d   = shadow_q;
      enable_d   = enable_q;
      valid_d    = valid_q;
      timeout_d  = timeout_q;

      if (write) begin
         case (address)
            ADDR_STATUS: begin
               if (writedata[STATUS_VALID_BIT])   valid_d   = 1'b0;
               if (writedata[STATUS_TIMEOUT_BIT]) timeout_d = 1'b0;
            end
            ADDR_CTRL: enable_d = writedata[CTRL_ENABLE_BIT];
            default: ;
         endcase
      end
      if (valid_set)   valid_d   = 1'b1;
      if (timeout_set) timeout_d = 1'b1;

      if (read) begin
         case (address)
            ADDR_HIGH: begin
               readdata_d = 32'(high_q);
               shadow_d   = period_q;
            end
            ADDR_PERIOD: readdata_d = 32'(shadow_q);
            ADDR_STATUS: begin
               readdata_d[STATUS_VALID_BIT]   = valid_q;
               readdata_d[STATUS_TIMEOUT_BIT] = timeout_q;
               readdata_d[STATUS_PWM_BIT]     = pwm_s;
            end
            default: readdata_d[CTRL_ENABLE_BIT] = enable_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         hcnt_q     <= '0;
         pcnt_q     <= '0;
         h_hold_q   <= '0;
         high_q     <= '0;
         period_q   <= '0;
         shadow_q   <= '0;
         tcnt_q     <= '0;
         valid_q    <= 1'b0;
         timeout_q  <= 1'b0;
         enable_q   <= 1'b0;
         readdata_q <= '0;
      end else begin
         state_q    <= state_d;
         hcnt_q     <= hcnt_d;
         pcnt_q     <= pcnt_d;
         h_hold_q   <= h_hold_d;
         high_q     <= high_d;
         period_q   <= period_d;
         shadow_q   <= shadow_d;
         tcnt_q     <= tcnt_d;
         valid_q    <= valid_d;
         timeout_q  <= timeout_d;
         enable_q   <= enable_d;
         readdata_q <= readdata_d;
      end
   end

   assign readdata = readdata_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: a 24-bit instance and an 8-bit
// instance share the bus and pwm_in so saturation is observed alongside.
module tb_pwm_capture;
   import pwm_capture_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  address;
   logic        read;
   logic        write;
   logic [31:0] writedata;
   logic        pwm_in;
   logic [31:0] readdata;
   logic [31:0] readdata8;

   int checks = 0;
   int errors = 0;
   bit done   = 1'b0;

   logic [31:0] d, d8;

   typedef struct {
      int hi;
      int lo;
      int reps;
      int exp_high;
      int exp_period;
      int exp_high8;
      int exp_period8;
   } vec_t;

   vec_t vecs[9];

   always #5 clk = ~clk;

   pwm_capture #(.CNT_W(24), .TIMEOUT(1000)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .address   (address),
      .read      (read),
      .readdata  (readdata),
      .write     (write),
      .writedata (writedata),
      .pwm_in    (pwm_in)
   );

   pwm_capture #(.CNT_W(8), .TIMEOUT(1000)) dut8 (
      .clk       (clk),
      .reset_n   (reset_n),
      .address   (address),
      .read      (read),
      .readdata  (readdata8),
      .write     (write),
      .writedata (writedata),
      .pwm_in    (pwm_in)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic level, input int cycles);
      pwm_in = level;
      repeat (cycles) @(negedge clk);
   endtask

   task automatic drivePeriods(input int hi, input int lo, input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b1, hi);
         applyStimulus(1'b0, lo);
      end
   endtask

   task automatic readReg(input logic [1:0] a, output logic [31:0] v,
                          output logic [31:0] v8);
      address = a;
      read    = 1'b1;
      @(negedge clk);
      read = 1'b0;
      v    = readdata;
      v8   = readdata8;
   endtask

   task automatic writeReg(input logic [1:0] a, input logic [31:0] v);
      address   = a;
      writedata = v;
      write     = 1'b1;
      @(negedge clk);
      write = 1'b0;
   endtask

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vecs[0] = '{hi: 100, lo: 400, reps: 3, exp_high: 100, exp_period: 500, exp_high8: 100, exp_period8: 255};
      vecs[1] = '{hi: 250, lo: 250, reps: 3, exp_high: 250, exp_period: 500, exp_high8: 250, exp_period8: 255};
      vecs[2] = '{hi: 280, lo: 20,  reps: 3, exp_high: 280, exp_period: 300, exp_high8: 255, exp_period8: 255};
      vecs[3] = '{hi: 1,   lo: 1,   reps: 4, exp_high: 1,   exp_period: 2,   exp_high8: 1,   exp_period8: 2};
      vecs[4] = '{hi: 1,   lo: 2,   reps: 3, exp_high: 1,   exp_period: 3,   exp_high8: 1,   exp_period8: 3};
      vecs[5] = '{hi: 2,   lo: 1,   reps: 3, exp_high: 2,   exp_period: 3,   exp_high8: 2,   exp_period8: 3};
      vecs[6] = '{hi: 3,   lo: 7,   reps: 3, exp_high: 3,   exp_period: 10,  exp_high8: 3,   exp_period8: 10};
      vecs[7] = '{hi: 255, lo: 1,   reps: 3, exp_high: 255, exp_period: 256, exp_high8: 255, exp_period8: 255};
      vecs[8] = '{hi: 254, lo: 1,   reps: 3, exp_high: 254, exp_period: 255, exp_high8: 254, exp_period8: 255};

      reset_n   = 1'b0;
      address   = '0;
      read      = 1'b0;
      write     = 1'b0;
      writedata = '0;
      pwm_in    = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("readdata_in_reset", readdata, 32'd0);
      reset_n = 1'b1;
      @(negedge clk);
      for (int a = 0; a < 4; a++) begin
         readReg(2'(a), d, d8);
         checkOutput($sformatf("reset_reg%0d", a), d, 32'd0);
      end

      $display("[TB] basic capture 100/400");
      writeReg(ADDR_CTRL, 32'd1);
      readReg(ADDR_CTRL, d, d8);
      checkOutput("ctrl_enable", d, 32'd1);
      drivePeriods(100, 400, 1);
      readReg(ADDR_STATUS, d, d8);
      checkOutput("valid_after_first_rise", d & 32'd1, 32'd0);
      drivePeriods(100, 400, 2);
      applyStimulus(1'b0, 5);
      readReg(ADDR_STATUS, d, d8);
      checkOutput("basic_valid", d & 32'd1, 32'd1);
      readReg(ADDR_HIGH, d, d8);
      checkOutput("basic_high", d, 32'd100);
      checkOutput("basic_high8", d8, 32'd100);
      readReg(ADDR_PERIOD, d, d8);
      checkOutput("basic_period", d, 32'd500);
      checkOutput("basic_period8", d8, 32'd255);

      $display("[TB] duty change to 250/250 with back-to-back pair reads");
      done = 1'b0;
      fork
         begin
            drivePeriods(250, 250, 3);
            done = 1'b1;
         end
         begin
            logic [31:0] rh, rp, rx;
            bit ok;
            while (!done) begin
               readReg(ADDR_HIGH, rh, rx);
               readReg(ADDR_PERIOD, rp, rx);
               ok = (rh == 32'd250 && rp == 32'd500) ||
                    (rh == 32'd100 && rp >= 32'd500 && rp <= 32'd540);
               checks++;
               if (!ok) begin
                  errors++;
                  $display("[TB] FAIL coherent_pair: got HIGH=%0d PERIOD=%0d, required a matching pair", rh, rp);
               end
            end
         end
      join
      applyStimulus(1'b0, 5);
      readReg(ADDR_HIGH, d, d8);
      checkOutput("duty_high", d, 32'd250);
      readReg(ADDR_PERIOD, d, d8);
      checkOutput("duty_period", d, 32'd500);

      $display("[TB] W1C versus hardware set");
      writeReg(ADDR_STATUS, 32'd1);
      readReg(ADDR_STATUS, d, d8);
      checkOutput("w1c_clears_valid", d & 32'd1, 32'd0);
      pwm_in = 1'b1;
      @(negedge clk);
      @(negedge clk);
      writeReg(ADDR_STATUS, 32'd1);
      readReg(ADDR_STATUS, d, d8);
      checkOutput("w1c_race_status", d, 32'd5);

      $display("[TB] timeout");
      applyStimulus(1'b1, 97);
      applyStimulus(1'b0, 400);
      drivePeriods(100, 400, 1);
      applyStimulus(1'b0, 500);
      readReg(ADDR_STATUS, d, d8);
      checkOutput("timeout_not_yet", d & 32'd2, 32'd0);
      applyStimulus(1'b0, 200);
      readReg(ADDR_STATUS, d, d8);
      checkOutput("timeout_set", d & 32'd2, 32'd2);
      readReg(ADDR_HIGH, d, d8);
      checkOutput("timeout_high", d, 32'd0);
      readReg(ADDR_PERIOD, d, d8);
      checkOutput("timeout_period", d, 32'd0);
      writeReg(ADDR_STATUS, 32'd2);
      readReg(ADDR_STATUS, d, d8);
      checkOutput("timeout_cleared", d & 32'd2, 32'd0);

      $display("[TB] directed vector table");
      for (int i = 0; i < 9; i++) begin
         writeReg(ADDR_STATUS, 32'd1);
         drivePeriods(vecs[i].hi, vecs[i].lo, vecs[i].reps);
         applyStimulus(1'b0, 5);
         readReg(ADDR_STATUS, d, d8);
         checkOutput($sformatf("vec%0d_valid", i), d & 32'd1, 32'd1);
         readReg(ADDR_HIGH, d, d8);
         checkOutput($sformatf("vec%0d_high", i), d, 32'(vecs[i].exp_high));
         checkOutput($sformatf("vec%0d_high8", i), d8, 32'(vecs[i].exp_high8));
         readReg(ADDR_PERIOD, d, d8);
         checkOutput($sformatf("vec%0d_period", i), d, 32'(vecs[i].exp_period));
         checkOutput($sformatf("vec%0d_period8", i), d8, 32'(vecs[i].exp_period8));
      end

      $display("[TB] disable holds results");
      writeReg(ADDR_CTRL, 32'd0);
      writeReg(ADDR_STATUS, 32'd1);
      drivePeriods(50, 50, 3);
      applyStimulus(1'b0, 5);
      readReg(ADDR_STATUS, d, d8);
      checkOutput("disabled_valid", d & 32'd1, 32'd0);
      readReg(ADDR_HIGH, d, d8);
      checkOutput("disabled_high", d, 32'd254);
      readReg(ADDR_PERIOD, d, d8);
      checkOutput("disabled_period", d, 32'd255);

      $display("[TB] asynchronous reset mid-HIGH");
      writeReg(ADDR_CTRL, 32'd1);
      applyStimulus(1'b1, 20);
      address = ADDR_HIGH;
      read    = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("pre_reset_readdata", readdata, 32'd254);
      reset_n = 1'b0;
      #1;
      checkOutput("async_reset_readdata", readdata, 32'd0);
      read   = 1'b0;
      pwm_in = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      for (int a = 0; a < 4; a++) begin
         readReg(2'(a), d, d8);
         checkOutput($sformatf("post_reset_reg%0d", a), d, 32'd0);
      end
      writeReg(ADDR_CTRL, 32'd1);
      drivePeriods(50, 50, 2);
      applyStimulus(1'b0, 5);
      readReg(ADDR_STATUS, d, d8);
      checkOutput("post_reset_valid", d & 32'd1, 32'd1);
      readReg(ADDR_HIGH, d, d8);
      checkOutput("post_reset_high", d, 32'd50);
      readReg(ADDR_PERIOD, d, d8);
      checkOutput("post_reset_period", d, 32'd100);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
